// File: rtl/tile_addr_gen.sv
// tile_addr_gen
//   Two-level address sequencer for the on-chip SRAM. It walks a 2-D tile one
//   element per accepted handshake. Columns are the inner loop and rows are
//   the outer loop. Addresses are generated incrementally: +1 per column, and
//   +row_stride per row from a tracked row base. There is no multiplier.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last tile's final values
//   RUN   | addr_valid=1; an element is transferred on each addr_ready
//   DONE  | one-cycle completion pulse (done=1), then back to IDLE
//
// Ports
//   clk, n_rst                 clock, async active-low reset
//   start                      begin a tile (sampled only in IDLE)
//   base_addr, row_stride      tile origin and row pitch (latched on start)
//   num_rows, num_cols         tile dimensions (latched on start)
//   addr_out, row_idx, col_idx current element
//   addr_valid / addr_ready    element handshake
//   last                       current element is the final one of the tile
//   busy                       high in RUN and DONE
//   done                       one-cycle pulse on tile completion
module tile_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  num_rows,
  input  logic [DIM_W-1:0]  num_cols,
  input  logic [ADDR_W-1:0] row_stride,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [DIM_W-1:0]  row_idx,
  output logic [DIM_W-1:0]  col_idx,
  output logic              last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  rows_q, rows_d;
  logic [DIM_W-1:0]  cols_q, cols_d;

  logic              col_last;
  logic              row_last;
  logic              xfer;
  logic [ADDR_W-1:0] next_row_base;

  // rows_q/cols_q are never zero while in RUN, so the -1 cannot underflow
  // where the comparison matters. Indices stop at rows-1/cols-1 and
  // therefore never overflow, even for a 255x255 tile.
  assign col_last      = (col_q == (cols_q - DIM_W'(1)));
  assign row_last      = (row_q == (rows_q - DIM_W'(1)));
  assign next_row_base = row_base_q + stride_q;

  assign addr_valid = (state_q == ST_RUN);
  assign last       = addr_valid && row_last && col_last;
  assign xfer       = addr_valid && addr_ready;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign addr_out   = addr_q;
  assign row_idx    = row_q;
  assign col_idx    = col_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    stride_d   = stride_q;
    row_d      = row_q;
    col_d      = col_q;
    rows_d     = rows_q;
    cols_d     = cols_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rows_d   = num_rows;
          cols_d   = num_cols;
          stride_d = row_stride;
          if ((num_rows != '0) && (num_cols != '0)) begin
            state_d    = ST_RUN;
            addr_d     = base_addr;
            row_base_d = base_addr;
            row_d      = '0;
            col_d      = '0;
          end else begin
            // Empty tile: complete at once without presenting any address.
            state_d = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        if (xfer) begin
          if (row_last && col_last) begin
            state_d = ST_DONE;
          end else if (!col_last) begin
            col_d  = col_q + DIM_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            col_d      = '0;
            row_d      = row_q + DIM_W'(1);
            row_base_d = next_row_base;
            addr_d     = next_row_base;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      row_base_q <= '0;
      stride_q   <= '0;
      row_q      <= '0;
      col_q      <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      stride_q   <= stride_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
    end
  end

endmodule

// File: tb/tb_tile_addr_gen.sv
// tb_tile_addr_gen
//   Directed bench for tile_addr_gen. Inputs are driven and outputs sampled
//   on the falling clock edge, away from the active rising edge.
module tb_tile_addr_gen;

  localparam int ADDR_W = 16;
  localparam int DIM_W  = 8;

  logic              clk;
  logic              n_rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [DIM_W-1:0]  num_rows;
  logic [DIM_W-1:0]  num_cols;
  logic [ADDR_W-1:0] row_stride;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid;
  logic              addr_ready;
  logic [DIM_W-1:0]  row_idx;
  logic [DIM_W-1:0]  col_idx;
  logic              last;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_addr [16];
  int                exp_row  [16];
  int                exp_col  [16];

  tile_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .num_cols   (num_cols),
    .row_stride (row_stride),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .row_idx    (row_idx),
    .col_idx    (col_idx),
    .last       (last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Issue a one-cycle start; returns on the first cycle after acceptance.
  task automatic do_start(input logic [15:0] b, input int r, input int c, input logic [15:0] s);
    base_addr  = b;
    num_rows   = DIM_W'(r);
    num_cols   = DIM_W'(c);
    row_stride = s;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_addr"},  32'(addr_out),   32'h0);
    check({tag, "_row"},   32'(row_idx),    32'h0);
    check({tag, "_col"},   32'(col_idx),    32'h0);
    check({tag, "_valid"}, 32'(addr_valid), 32'h0);
    check({tag, "_last"},  32'(last),       32'h0);
    check({tag, "_busy"},  32'(busy),       32'h0);
    check({tag, "_done"},  32'(done),       32'h0);
  endtask

  // Walk n expected elements. bp selects ready pattern 1,0,0,1,0,0,...;
  // ign pulses start with a foreign config mid-run and again in DONE.
  task automatic run_tile(input string tag, input int n, input bit bp, input bit ign);
    int  k   = 0;
    int  cyc = 0;
    bit  rdy;
    while (k < n && cyc < 200) begin
      check({tag, "_valid"}, 32'(addr_valid), 32'h1);
      check({tag, "_addr"},  32'(addr_out),   32'(exp_addr[k]));
      check({tag, "_row"},   32'(row_idx),    32'(exp_row[k]));
      check({tag, "_col"},   32'(col_idx),    32'(exp_col[k]));
      check({tag, "_last"},  32'(last),       32'(k == n - 1));
      check({tag, "_busy"},  32'(busy),       32'h1);
      check({tag, "_done"},  32'(done),       32'h0);
      rdy = bp ? (cyc % 3 == 0) : 1'b1;
      addr_ready = rdy;
      if (ign && cyc == 1) begin
        base_addr  = 16'h5555;
        num_rows   = 8'd7;
        num_cols   = 8'd9;
        row_stride = 16'h0333;
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
      if (rdy) k++;
    end
    start      = 1'b0;
    addr_ready = 1'b1;
    check({tag, "_xfers"}, 32'(k), 32'(n));
    check({tag, "_dvalid"}, 32'(addr_valid), 32'h0);
    check({tag, "_done1"},  32'(done),       32'h1);
    check({tag, "_dbusy"},  32'(busy),       32'h1);
    check({tag, "_dlast"},  32'(last),       32'h0);
    check({tag, "_daddr"},  32'(addr_out),   32'(exp_addr[n-1]));
    check({tag, "_drow"},   32'(row_idx),    32'(exp_row[n-1]));
    check({tag, "_dcol"},   32'(col_idx),    32'(exp_col[n-1]));
    if (ign) start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_done0"}, 32'(done),       32'h0);
    check({tag, "_ibusy"}, 32'(busy),       32'h0);
    check({tag, "_ivld"},  32'(addr_valid), 32'h0);
    step();
    check({tag, "_ibusy2"}, 32'(busy),       32'h0);
    check({tag, "_ivld2"},  32'(addr_valid), 32'h0);
  endtask

  task automatic run_degenerate(input string tag, input int r, input int c);
    do_start(16'h0abc, r, c, 16'h0004);
    check({tag, "_valid"}, 32'(addr_valid), 32'h0);
    check({tag, "_done1"}, 32'(done),       32'h1);
    check({tag, "_busy1"}, 32'(busy),       32'h1);
    step();
    check({tag, "_valid2"}, 32'(addr_valid), 32'h0);
    check({tag, "_done0"},  32'(done),       32'h0);
    check({tag, "_busy0"},  32'(busy),       32'h0);
    step();
    check({tag, "_valid3"}, 32'(addr_valid), 32'h0);
    check({tag, "_done2"},  32'(done),       32'h0);
  endtask

  task automatic load_2x3();
    exp_addr[0] = 16'h0100; exp_row[0] = 0; exp_col[0] = 0;
    exp_addr[1] = 16'h0101; exp_row[1] = 0; exp_col[1] = 1;
    exp_addr[2] = 16'h0102; exp_row[2] = 0; exp_col[2] = 2;
    exp_addr[3] = 16'h0110; exp_row[3] = 1; exp_col[3] = 0;
    exp_addr[4] = 16'h0111; exp_row[4] = 1; exp_col[4] = 1;
    exp_addr[5] = 16'h0112; exp_row[5] = 1; exp_col[5] = 2;
  endtask

  initial begin
    n_rst      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    num_rows   = '0;
    num_cols   = '0;
    row_stride = '0;
    addr_ready = 1'b1;

    #12;
    check_idle_zero("rst_held");
    n_rst = 1'b1;
    step();
    check_idle_zero("rst_rel");

    // Basic 2x3 tile, ready held high.
    load_2x3();
    do_start(16'h0100, 2, 3, 16'h0010);
    run_tile("basic", 6, 1'b0, 1'b0);

    // Same tile under backpressure.
    do_start(16'h0100, 2, 3, 16'h0010);
    run_tile("bp", 6, 1'b1, 1'b0);

    // Empty tiles.
    run_degenerate("deg_r0", 0, 5);
    run_degenerate("deg_c0", 4, 0);

    // Single column with address wrap.
    exp_addr[0] = 16'hfffe; exp_row[0] = 0; exp_col[0] = 0;
    exp_addr[1] = 16'hffff; exp_row[1] = 1; exp_col[1] = 0;
    exp_addr[2] = 16'h0000; exp_row[2] = 2; exp_col[2] = 0;
    do_start(16'hfffe, 3, 1, 16'h0001);
    run_tile("wrap", 3, 1'b0, 1'b0);

    // Start during RUN and DONE is ignored.
    load_2x3();
    do_start(16'h0100, 2, 3, 16'h0010);
    run_tile("ign", 6, 1'b0, 1'b1);

    exp_addr[0] = 16'h0042; exp_row[0] = 0; exp_col[0] = 0;
    do_start(16'h0042, 1, 1, 16'h0000);
    run_tile("one", 1, 1'b0, 1'b0);

    // Reset in the middle of a 4x4 tile, after two transfers.
    do_start(16'h0200, 4, 4, 16'h0020);
    step();
    step();
    check("mid_addr", 32'(addr_out), 32'h0202);
    check("mid_col",  32'(col_idx),  32'h2);
    #2;
    n_rst = 1'b0;
    #1;
    check_idle_zero("arst");
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_nodone", 32'(done), 32'h0);
    end
    n_rst = 1'b1;
    step();
    check_idle_zero("arst_rel");

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        exp_addr[r*4+c] = 16'h0300 + 16'(r * 16'h0020) + 16'(c);
        exp_row[r*4+c]  = r;
        exp_col[r*4+c]  = c;
      end
    end
    do_start(16'h0300, 4, 4, 16'h0020);
    run_tile("post", 16, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
